// File: rtl/aes_128_pkg.sv
// Shared types and constants for the on-the-fly AES-128 key schedule.
// The S-box table and lookup helper live here so any datapath can reuse them.
package aes_128_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef logic [31:0] aes_word_t;

  localparam int NR_C  = 10;
  localparam int KEY_W = 128;

  // Indexed by the round being produced (1..10); the unused slots read as 0.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry b starts at bit 2047-8b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] hi;
    hi = ~{b, 3'b000};
    return SBOX_TBL[hi -: 8];
  endfunction

endpackage

// File: rtl/aes_128_key_expander_if.sv
// Control/key bus between the round controller (master) and the key expander (slave).
// key_rewind_i exists only when AES_KEY_RETAIN_EN is defined.
interface aes_128_key_expander_if;
  import aes_128_pkg::*;

  // Pulses are single-cycle, sampled on the rising edge; outputs are registered
  // and key_valid_o qualifies round_key_o/round_idx_o with no back-pressure.
  logic         key_load_i;
  logic [127:0] key_i;
  logic         round_adv_i;
`ifdef AES_KEY_RETAIN_EN
  logic         key_rewind_i;
`endif
  logic [127:0] round_key_o;
  logic [3:0]   round_idx_o;
  logic         key_valid_o;
  logic         busy_o;
  logic         last_round_o;
  state_e       dbg_state;

  modport master (
`ifdef AES_KEY_RETAIN_EN
    output key_rewind_i,
`endif
    output key_load_i, key_i, round_adv_i,
    input  round_key_o, round_idx_o, key_valid_o, busy_o, last_round_o, dbg_state
  );

  modport slave (
`ifdef AES_KEY_RETAIN_EN
    input  key_rewind_i,
`endif
    input  key_load_i, key_i, round_adv_i,
    output round_key_o, round_idx_o, key_valid_o, busy_o, last_round_o, dbg_state
  );

endinterface

// File: rtl/aes_128_sub_word.sv
// SubWord: four parallel combinational S-box lookups on one 32-bit word.
module aes_128_sub_word
  import aes_128_pkg::*;
(
  input  aes_word_t word_i,
  output aes_word_t word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_128_key_expander.sv
// On-the-fly AES-128 key schedule: one round key per advance, final key flagged.
// Define AES_KEY_RETAIN_EN to keep a shadow copy of the cipher key for rewinding.
module aes_128_key_expander
  import aes_128_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  aes_128_key_expander_if.slave bus
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, key_nxt, rewind_key;
  logic [3:0]       idx_q, idx_d, idx_nxt;
  aes_word_t        w0, w1, w2, w3, rot_w3, sub_w3, t_w, n0, n1, n2, n3;
  logic             adv_go, rewind_go;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_128_sub_word u_sub_word (
    .word_i (rot_w3),
    .word_o (sub_w3)
  );

  assign idx_nxt = idx_q + 4'd1;
  assign t_w     = sub_w3 ^ {RCON[idx_nxt], 24'h000000};
  assign n0      = w0 ^ t_w;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign key_nxt = {n0, n1, n2, n3};

  // Advances only count while expanding, which also pins the index at 10.
  assign adv_go = bus.round_adv_i && (state_q == ST_EXPAND);

`ifdef AES_KEY_RETAIN_EN
  logic [KEY_W-1:0] shadow_q, shadow_d;

  assign shadow_d   = bus.key_load_i ? bus.key_i : shadow_q;
  assign rewind_go  = bus.key_rewind_i && (state_q != ST_IDLE);
  assign rewind_key = shadow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end
`else
  assign rewind_go  = 1'b0;
  assign rewind_key = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_EXPAND: if (adv_go && idx_q == 4'(NR_C - 1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.key_load_i || rewind_go) state_d = ST_EXPAND;
  end

  // Load beats rewind beats advance.
  always_comb begin
    key_d = key_q;
    idx_d = idx_q;
    if (bus.key_load_i) begin
      key_d = bus.key_i;
      idx_d = '0;
    end else if (rewind_go) begin
      key_d = rewind_key;
      idx_d = '0;
    end else if (adv_go) begin
      key_d = key_nxt;
      idx_d = idx_nxt;
    end
  end

  always_comb begin
    bus.round_key_o  = key_q;
    bus.round_idx_o  = idx_q;
    bus.key_valid_o  = (state_q != ST_IDLE);
    bus.busy_o       = (state_q == ST_EXPAND);
    bus.last_round_o = (state_q == ST_DONE);
    bus.dbg_state    = state_q;
  end

endmodule

// File: tb/tb_aes_128_key_expander.sv
// Self-checking bench for aes_128_key_expander using FIPS-197 key schedule vectors.
// Builds with or without AES_KEY_RETAIN_EN.
module tb_aes_128_key_expander;
  import aes_128_pkg::*;

  localparam int W = 137;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  vec_t vecs[11];

  aes_128_key_expander_if bus_if ();

  aes_128_key_expander dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_rk(input logic [127:0] k, input logic [3:0] idx);
    if (idx == 4'd10) return {k, idx, 1'b1, 1'b0, 1'b1, 2'(ST_DONE)};
    return {k, idx, 1'b1, 1'b1, 1'b0, 2'(ST_EXPAND)};
  endfunction

  function automatic logic [W-1:0] observe();
    return {bus_if.round_key_o, bus_if.round_idx_o, bus_if.key_valid_o,
            bus_if.busy_o, bus_if.last_round_o, 2'(bus_if.dbg_state)};
  endfunction

  task automatic clear_pulses();
    bus_if.key_load_i  = 1'b0;
    bus_if.round_adv_i = 1'b0;
`ifdef AES_KEY_RETAIN_EN
    bus_if.key_rewind_i = 1'b0;
`endif
  endtask

  // One clock: the expected entry pushed before the edge is checked just after it.
  task automatic cycle(input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] got;
    @(posedge clk);
    #1;
    clear_pulses();
    got = observe();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got=%h", name, got);
    end else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s: got=%h exp=%h", name, got, exp_v);
      end
    end
  endtask

  task automatic do_load(input logic [127:0] k, input string name);
    bus_if.key_load_i = 1'b1;
    bus_if.key_i      = k;
    exp_q.push_back(exp_rk(k, 4'd0));
    cycle(name);
  endtask

  task automatic do_adv(input logic [W-1:0] exp_v, input string name);
    bus_if.round_adv_i = 1'b1;
    exp_q.push_back(exp_v);
    cycle(name);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus_if.key_i = '0;
    clear_pulses();

    vecs[0]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0};
    vecs[1]  = '{128'ha0fafe1788542cb123a339392a6c7605, 4'd1};
    vecs[2]  = '{128'hf2c295f27a96b9435935807a7359f67f, 4'd2};
    vecs[3]  = '{128'h3d80477d4716fe3e1e237e446d7a883b, 4'd3};
    vecs[4]  = '{128'hef44a541a8525b7fb671253bdb0bad00, 4'd4};
    vecs[5]  = '{128'hd4d1c6f87c839d87caf2b8bc11f915bc, 4'd5};
    vecs[6]  = '{128'h6d88a37a110b3efddbf98641ca0093fd, 4'd6};
    vecs[7]  = '{128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 4'd7};
    vecs[8]  = '{128'head27321b58dbad2312bf5607f8d292f, 4'd8};
    vecs[9]  = '{128'hac7766f319fadc2128d12941575c006e, 4'd9};
    vecs[10] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10};

    // Reset held two cycles, then advances in IDLE must not move anything.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      cycle("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_adv('0, "idle_adv");
`ifdef AES_KEY_RETAIN_EN
    bus_if.key_rewind_i = 1'b1;
    exp_q.push_back('0);
    cycle("idle_rewind");
`endif

    // FIPS-197 A.1 full schedule from the vector table.
    do_load(vecs[0].key, "a1_load");
    for (int i = 1; i <= 10; i++) do_adv(exp_rk(vecs[i].key, vecs[i].idx), "a1_adv");

    // Saturation: 12 back-to-back advances stop at round 10.
    do_load(vecs[0].key, "sat_load");
    for (int i = 1; i <= 12; i++) begin
      int j;
      j = (i > 10) ? 10 : i;
      do_adv(exp_rk(vecs[j].key, vecs[j].idx), "sat_adv");
    end
    do_adv(exp_rk(vecs[10].key, 4'd10), "done_hold");

    // Load and advance together at round 4: load wins.
    do_load(vecs[0].key, "col_load");
    for (int i = 1; i <= 4; i++) do_adv(exp_rk(vecs[i].key, vecs[i].idx), "col_pre");
    bus_if.round_adv_i = 1'b1;
    do_load(128'h0, "col_both");
    do_adv(exp_rk(128'h62636363626363636263636362636363, 4'd1), "col_adv");

    // Reset in the middle of expansion, then a clean restart.
    do_load(vecs[0].key, "mid_load");
    for (int i = 1; i <= 6; i++) do_adv(exp_rk(vecs[i].key, vecs[i].idx), "mid_pre");
    rst = 1'b1;
    do_adv('0, "mid_rst");
    rst = 1'b0;
    do_adv('0, "post_rst_adv");
    do_load(vecs[0].key, "reload");
    do_adv(exp_rk(vecs[1].key, 4'd1), "reload_adv");

    // Reuse of the key after a full schedule: rewind when retained, else reload.
    for (int i = 2; i <= 10; i++) do_adv(exp_rk(vecs[i].key, vecs[i].idx), "reuse_pre");
`ifdef AES_KEY_RETAIN_EN
    bus_if.key_rewind_i = 1'b1;
    bus_if.round_adv_i  = 1'b1;
    exp_q.push_back(exp_rk(vecs[0].key, 4'd0));
    cycle("rewind");
`else
    do_load(vecs[0].key, "reuse_load");
`endif
    for (int i = 1; i <= 10; i++) do_adv(exp_rk(vecs[i].key, vecs[i].idx), "reuse_adv");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got=%0d exp=0", exp_q.size());
    end
    checks++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
